instr_dispatch_fsm: RTL and testbench

Top-level sequencer for the shared-bus datapath. Fetches 16-bit instruction words from a synchronous instruction ROM and decodes the opcode. Starts the matching operation FSM (MOV, ALU ops, ...) through a shared fsm_start code plus source/dest operand fields, then waits for that FSM's done before advancing the PC. Provides halt, stop and watchdog-timeout handling so that a hung operation FSM cannot stall the design silently.

---
 rtl/ssm_pkg.sv | 51 +++++
 rtl/instr_dispatch_fsm_if.sv | 30 +++
 rtl/dispatch_watchdog.sv | 28 ++
 rtl/instr_dispatch_fsm.sv | 149 ++++++++++++++
 tb/tb_instr_dispatch_fsm.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssm_pkg.sv
// Shared definitions for the shared-bus sequencer: opcodes, instruction field
// layout, dispatcher state encoding and small decode helpers.
package ssm_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int FIELD_W = 6;
    localparam int OPC_LSB = 12;
    localparam int SRC_LSB = 6;
    localparam int DST_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_NEXT,
        ST_HALT,
        ST_ERROR
    } disp_state_e;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [FIELD_W-1:0] instr_source(input logic [INSTR_W-1:0] w);
        return w[SRC_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] instr_dest(input logic [INSTR_W-1:0] w);
        return w[DST_LSB +: FIELD_W];
    endfunction

    // IDLE, HALT and ERROR are the only states where the sequencer is parked.
    function automatic logic state_is_busy(input disp_state_e s);
        return !((s == ST_IDLE) || (s == ST_HALT) || (s == ST_ERROR));
    endfunction

endpackage

// File: rtl/instr_dispatch_fsm_if.sv
// Instruction ROM port plus the start/operand/done handshake towards the
// operation FSMs.
interface instr_dispatch_fsm_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic [3:0]          fsm_start;
    logic [5:0]          source;
    logic [5:0]          dest;
    logic                fsm_done;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output fsm_start,
        output source,
        output dest,
        input  fsm_done
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  fsm_start,
        input  source,
        input  dest,
        output fsm_done
    );
endinterface

// File: rtl/dispatch_watchdog.sv
// Cycle counter guarding WAIT_DONE: cleared on issue, counts while enabled and
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module dispatch_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;
    logic        w_expired;

    assign w_expired = (r_count == LAST_COUNT);
    assign o_expired = w_expired;

    // Saturates at the limit so a lingering enable can never wrap back to zero.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + 16'd1;
        end
    end
endmodule

// File: rtl/instr_dispatch_fsm.sv
// Top-level sequencer: fetches from the instruction ROM, decodes, issues a
// start code to the operation FSMs and waits (under watchdog) for done.
module instr_dispatch_fsm
    import ssm_pkg::*;
#(
    parameter int PC_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic                 i_stop,
    instr_dispatch_fsm_if.master bus,
    output logic [PC_WIDTH-1:0]  o_pc,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_error
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    disp_state_e         r_state;
    disp_state_e         w_next_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [3:0]          r_fsm_start;
    logic [5:0]          r_source;
    logic [5:0]          r_dest;
    logic                r_busy;
    logic                r_halted;
    logic                r_error;
    logic                r_stop_pending;

    logic [3:0]          w_opcode;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_wd_expired;

    assign w_opcode = instr_opcode(bus.imem_rdata);

    dispatch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_wd_clear   = 1'b0;
        w_wd_enable  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_opcode == OP_NOP) begin
                    w_next_state = ST_NEXT;
                end else if (w_opcode == OP_HALT) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_wd_clear   = 1'b1;
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                w_wd_enable = 1'b1;
                // A done arriving in the expiry cycle still completes the op.
                if (bus.fsm_done) begin
                    w_next_state = ST_NEXT;
                end else if (w_wd_expired) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_NEXT: begin
                // A stop arriving in this very cycle is honoured as well.
                if (r_stop_pending || i_stop) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_pc           <= '0;
            r_fsm_start    <= '0;
            r_source       <= '0;
            r_dest         <= '0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
            r_error        <= 1'b0;
            r_stop_pending <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= state_is_busy(w_next_state);
            // Registered so the start code is visible for exactly the ISSUE cycle.
            r_fsm_start <= (w_next_state == ST_ISSUE) ? w_opcode : 4'h0;
            if (w_next_state == ST_ISSUE) begin
                r_source <= instr_source(bus.imem_rdata);
                r_dest   <= instr_dest(bus.imem_rdata);
            end
            if (r_state == ST_NEXT) begin
                r_pc <= r_pc + PC_ONE;
            end
            if (w_next_state == ST_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_next_state == ST_ERROR) begin
                r_error <= 1'b1;
            end
            if (r_state == ST_NEXT) begin
                r_stop_pending <= 1'b0;
            end else if (i_stop && r_busy) begin
                r_stop_pending <= 1'b1;
            end
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.fsm_start = r_fsm_start;
    assign bus.source    = r_source;
    assign bus.dest      = r_dest;
    assign o_pc          = r_pc;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_error       = r_error;
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Self-checking bench: directed and randomized programs run against a
// transaction-level model of instruction timing, issue and termination.
module tb_instr_dispatch_fsm;
    import ssm_pkg::*;

    localparam int PCW  = 8;
    localparam int T    = 8;
    localparam int NPC  = 1 << PCW;
    localparam int K_IDLE = 0;
    localparam int K_HALT = 1;
    localparam int K_ERR  = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           run   = 1'b0;
    logic           stop  = 1'b0;
    logic [PCW-1:0] pc;
    logic           busy;
    logic           halted;
    logic           error;

    instr_dispatch_fsm_if #(.PC_WIDTH(PCW)) bus ();

    instr_dispatch_fsm #(
        .PC_WIDTH       (PCW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_run    (run),
        .i_stop   (stop),
        .bus      (bus),
        .o_pc     (pc),
        .o_busy   (busy),
        .o_halted (halted),
        .o_error  (error)
    );

    always #5 clock = ~clock;

    // Synchronous instruction ROM.
    logic [15:0] rom [NPC];
    always @(posedge clock) bus.imem_rdata <= rom[bus.imem_addr];

    // Operation FSM stand-in: done arrives in the Nth WAIT_DONE cycle; N=0 hangs.
    int dly [1024];
    int dly_idx = 0;
    int cnt = 0;
    always @(posedge clock) begin
        if (reset) begin
            cnt <= 0;
        end else if (bus.fsm_start != 4'h0) begin
            cnt     <= dly[dly_idx];
            dly_idx <= dly_idx + 1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end
    assign bus.fsm_done = (cnt == 1);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; int op; int src; int dst; int pc; } iss_t;
    iss_t obs_q[$];
    int   done_q[$];
    always @(negedge clock) begin
        if (bus.fsm_start != 4'h0)
            obs_q.push_back('{cyc, int'(bus.fsm_start), int'(bus.source), int'(bus.dest), int'(pc)});
        if (bus.fsm_done)
            done_q.push_back(int'({bus.source, bus.dest}));
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (failure %0d)", tag, obs, exp, fails);
        end
    endtask

    // Reference model: walks the program instruction by instruction.
    iss_t exp_q[$];
    int   exp_end, exp_pc, exp_kind;
    task automatic model_exec(input int start_pc, input int stop_off);
        int p, t, k, len, d;
        logic [15:0] w;
        p = start_pc; t = 0; k = dly_idx;
        exp_q.delete();
        exp_end = -1; exp_pc = -1; exp_kind = -1;
        for (int n = 0; n < 2000; n++) begin
            w = rom[p];
            if (w[15:12] == OP_HALT) begin
                exp_end = t + 2; exp_pc = p; exp_kind = K_HALT;
                return;
            end
            if (w[15:12] == OP_NOP) begin
                len = 3;
            end else begin
                d = dly[k]; k++;
                exp_q.push_back('{t + 2, int'(w[15:12]), int'(w[11:6]), int'(w[5:0]), p});
                if (d < 1 || d > T) begin
                    exp_end = t + 3 + T; exp_pc = p; exp_kind = K_ERR;
                    return;
                end
                len = 4 + d;
            end
            if (stop_off >= t && stop_off < t + len) begin
                exp_end = t + len; exp_pc = (p + 1) % NPC; exp_kind = K_IDLE;
                return;
            end
            t += len;
            p = (p + 1) % NPC;
        end
    endtask

    int t0;
    task automatic do_run(input string tag, input int start_pc, input int stop_off);
        int end_off;
        int n_done;
        model_exec(start_pc, stop_off);
        obs_q.delete();
        done_q.delete();
        @(negedge clock);
        run = 1'b1;
        t0 = cyc + 1;
        end_off = -1;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clock);
            run = 1'b0;
            if (!busy) begin
                end_off = cyc - t0;
                break;
            end
            stop = ((cyc - t0) == stop_off);
        end
        stop = 1'b0;
        $display("run %s: start_pc=%0d end_cycle=%0d pc=%0d halted=%0b error=%0b issues=%0d",
                 tag, start_pc, end_off, pc, halted, error, obs_q.size());
        chk({tag, " end_cycle"}, end_off, exp_end);
        chk({tag, " pc"}, 32'(pc), exp_pc);
        chk({tag, " halted"}, 32'(halted), 32'(exp_kind == K_HALT));
        chk({tag, " error"}, 32'(error), 32'(exp_kind == K_ERR));
        chk({tag, " fsm_start_idle"}, 32'(bus.fsm_start), 0);
        chk({tag, " issue_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s issue%0d cycle", tag, i), obs_q[i].cyc - t0, exp_q[i].cyc);
            chk($sformatf("%s issue%0d opcode", tag, i), obs_q[i].op, exp_q[i].op);
            chk($sformatf("%s issue%0d source", tag, i), obs_q[i].src, exp_q[i].src);
            chk($sformatf("%s issue%0d dest", tag, i), obs_q[i].dst, exp_q[i].dst);
            chk($sformatf("%s issue%0d pc", tag, i), obs_q[i].pc, exp_q[i].pc);
        end
        n_done = exp_q.size() - ((exp_kind == K_ERR) ? 1 : 0);
        chk({tag, " done_count"}, done_q.size(), n_done);
        for (int i = 0; i < done_q.size() && i < n_done; i++)
            chk($sformatf("%s done%0d operands", tag, i), done_q[i], exp_q[i].src * 64 + exp_q[i].dst);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < NPC; i++) rom[i] = w;
    endtask

    logic [3:0] op_tab [9];
    logic [15:0] word;
    int plen, soff;

    initial begin
        op_tab[0] = OP_ADD; op_tab[1] = OP_SUB; op_tab[2] = OP_AND;
        op_tab[3] = OP_MOV; op_tab[4] = OP_OR;  op_tab[5] = OP_XOR;
        op_tab[6] = OP_SHL; op_tab[7] = OP_SHR; op_tab[8] = 4'hA;
        for (int i = 0; i < 1024; i++) dly[i] = 1;
        fill_rom({OP_HALT, 12'h000});

        // Reset values
        do_reset();
        chk("reset pc", 32'(pc), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset halted", 32'(halted), 0);
        chk("reset error", 32'(error), 0);
        chk("reset fsm_start", 32'(bus.fsm_start), 0);
        chk("reset source", 32'(bus.source), 0);
        chk("reset dest", 32'(bus.dest), 0);

        // MOV with done three cycles after start, then HALT
        rom[0] = 16'h4045;
        rom[1] = {OP_HALT, 12'h000};
        dly[dly_idx] = 3;
        do_run("mov", 0, -1);

        // NOP, NOP, HALT
        do_reset();
        fill_rom({OP_HALT, 12'h000});
        rom[0] = 16'h0000;
        rom[1] = 16'h0FFF;
        do_run("nop_halt", 0, -1);

        // Hung operation: watchdog error, run ignored afterwards
        do_reset();
        rom[0] = 16'h4045;
        dly[dly_idx] = 0;
        do_run("timeout", 0, -1);
        run = 1'b1;
        repeat (10) @(negedge clock);
        run = 1'b0;
        chk("after_error error", 32'(error), 1);
        chk("after_error busy", 32'(busy), 0);
        chk("after_error pc", 32'(pc), 0);
        chk("after_error issue_count", obs_q.size(), exp_q.size());

        // Done coinciding with the last watchdog cycle
        do_reset();
        rom[0] = 16'h4045;
        rom[1] = {OP_HALT, 12'h000};
        dly[dly_idx] = T;
        do_run("done_at_timeout", 0, -1);

        // Stop in IDLE is not latched
        do_reset();
        rom[0] = {OP_ADD, 6'd9, 6'd17};
        rom[1] = 16'h0000;
        rom[2] = {OP_HALT, 12'h000};
        dly[dly_idx] = 2;
        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        do_run("stop_in_idle", 0, -1);

        // Stop during WAIT_DONE, then resume at the new pc
        do_reset();
        rom[0] = {OP_ADD, 6'd33, 6'd2};
        rom[1] = {OP_MOV, 6'd7, 6'd63};
        rom[2] = {OP_HALT, 12'h000};
        dly[dly_idx] = 4;
        dly[dly_idx + 1] = 2;
        do_run("stop_wait_done", 0, 4);
        do_run("resume", exp_pc, -1);

        // Park at pc=255 via stop, then wrap through NOP to ROM[0]
        do_reset();
        fill_rom(16'h0000);
        do_run("walk_to_ff", 0, 3 * (NPC - 2));
        rom[0] = {OP_XOR, 6'd21, 6'd42};
        rom[1] = {OP_HALT, 12'h000};
        dly[dly_idx] = 2;
        do_run("wrap", exp_pc, -1);

        // Reset in the middle of WAIT_DONE
        do_reset();
        fill_rom({OP_HALT, 12'h000});
        rom[0] = 16'h0000;
        rom[1] = 16'h4045;
        dly[dly_idx] = 0;
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        repeat (7) @(negedge clock);
        chk("mid_wait busy", 32'(busy), 1);
        chk("mid_wait source", 32'(bus.source), 1);
        chk("mid_wait dest", 32'(bus.dest), 5);
        chk("mid_wait pc", 32'(pc), 1);
        reset = 1'b1;
        @(negedge clock);
        $display("reset mid-wait: pc=%0d busy=%0b source=%0d dest=%0d", pc, busy, bus.source, bus.dest);
        chk("mid_reset pc", 32'(pc), 0);
        chk("mid_reset busy", 32'(busy), 0);
        chk("mid_reset source", 32'(bus.source), 0);
        chk("mid_reset dest", 32'(bus.dest), 0);
        chk("mid_reset fsm_start", 32'(bus.fsm_start), 0);
        chk("mid_reset halted", 32'(halted), 0);
        chk("mid_reset error", 32'(error), 0);
        reset = 1'b0;

        // Randomized programs with random delays and optional stop
        for (int r = 0; r < 6; r++) begin
            do_reset();
            fill_rom({OP_HALT, 12'h000});
            plen = $urandom_range(3, 20);
            for (int i = 0; i < plen; i++) begin
                word[11:0] = 12'($urandom);
                word[15:12] = ($urandom_range(0, 3) == 0) ? OP_NOP : op_tab[$urandom_range(0, 8)];
                rom[i] = word;
                dly[dly_idx + i] = $urandom_range(1, T);
            end
            soff = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3 * plen)) : -1;
            do_run($sformatf("rand%0d", r), 0, soff);
            if (exp_kind == K_IDLE)
                do_run($sformatf("rand%0d_resume", r), exp_pc, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
